bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
- Multi-digit packed-BCD subtractor; the inverse operation to the team's BCD adder.
- Computes diff = a - b - bin, one BCD digit per clock, least-significant digit first, using a start/ready/done handshake.
- Sits beside the BCD adder in the decimal arithmetic datapath and feeds counters and display logic that consume packed BCD.

Parameters:
- DIGITS, 4, number of BCD digits per operand (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0].
- b  input  4*DIGITS  subtrahend, packed BCD.
- bin  input  1  borrow-in.
- ready  output  1  high in IDLE; block accepts start.
- done  output  1  one-cycle pulse; diff/bout/invalid valid.
- diff  output  4*DIGITS  packed BCD result.
- bout  output  1  final borrow-out (1 = result negative).
- invalid  output  1  some a or b digit was >9 in this operation.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high. On rst: state=IDLE, ready=1, done=0, diff=0, bout=0, invalid=0, internal registers cleared.
- rst dominates everything, including mid-operation: the in-flight operation is abandoned and no done pulse is produced.
- FSM states:
  - IDLE -> SUB on start & ready. At that edge: latch a, b, bin into internal registers; set digit index=0, borrow=bin, invalid=0; drop ready.
  - SUB: one digit per edge. t = a_i - b_i - borrow, computed in 5-bit signed arithmetic on the raw 4-bit digit values.
    - If t<0: d=(t+10)[3:0], borrow=1.
    - Else: d=t[3:0], borrow=0.
    - Write d into diff digit i.
    - If a_i>9 or b_i>9: set invalid (sticky until the next start).
    - After digit DIGITS-1: bout=borrow, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE with ready=1.
- Latency: start sampled at edge E0; done is high during the cycle after edge E(DIGITS), i.e. DIGITS+1 cycles from the accepting edge to the done pulse.
- Throughput: one operation every DIGITS+2 cycles.
- start while ready=0 is ignored; it is not queued.
- Input changes after the accepting edge have no effect on the operation in flight.
- diff, bout and invalid hold their values from done until the next accepted start. diff digits update progressively during SUB.
- Negative result without the optional feature: diff is the ten's complement, (a - b - bin + 10^DIGITS), with bout=1.
- Invalid digits: the same arithmetic rule is applied. Example: a_i=0xA, b_i=0, borrow=0 gives d=0xA, borrow=0. The output is deterministic and not corrected.

Optional Feature:
- Macro: BCD_SUB_SIGN_MAG_EN.
- Defined:
  - If bout=1 after SUB, the FSM enters state NEG, which runs DIGITS more cycles computing 0 - diff_i - borrow with the same digit rule and initial borrow=0, so diff becomes the magnitude.
  - bout stays 1 as the sign bit.
  - done then occurs 2*DIGITS+1 cycles after the accepting edge.
  - If bout=0, NEG is skipped.
  - invalid is unaffected by the NEG pass.
- Undefined: no NEG state; the result is left in ten's complement form.

Test Plan (DIGITS=4):
- a=0x5432, b=0x1234, bin=0 -> diff=0x4198, bout=0, invalid=0; done exactly 5 cycles after the accepting edge; ready returns 1 the cycle after done.
- a=0x1000, b=0x0001, bin=0 -> borrow ripples through three digits; diff=0x0999, bout=0.
- a=0x0000, b=0x0001, bin=0 -> macro undefined: diff=0x9999, bout=1, done at cycle 5. Macro defined: diff=0x0001, bout=1, done at cycle 9.
- a=0x0123, b=0x0123, bin=1 -> undefined: diff=0x9999, bout=1. Defined: diff=0x0001, bout=1. With bin=0 -> diff=0x0000, bout=0 in both builds (no NEG pass, done at cycle 5).
- Pulse start again two cycles after acceptance with different operands -> ignored; the original result is reported. Assert rst during SUB -> the next cycle shows ready=1, diff=0, bout=0, and no done pulse follows.
- a=0x00A0, b=0x0000, bin=0 -> invalid=1, diff=0x00A0, bout=0; the next valid operation clears invalid at its accepting edge.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to convert negative results to sign/magnitude (extra NEG pass).
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
`ifdef BCD_SUB_SIGN_MAG_EN
    S_NEG,
`endif
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             invalid_q, invalid_d;

  logic [IDX_W+1:0] base;
  logic [3:0]       digit_a, digit_b;
  logic [4:0]       res;
  logic             last;

  // Returns {borrow_out, digit}; the raw 5-bit difference is negative exactly when bit 4 is set.
  function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic borrow_in);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0, borrow_in};
    if (t[4]) digit_sub = {1'b1, t[3:0] + 4'd10};
    else      digit_sub = {1'b0, t[3:0]};
  endfunction

  always_comb begin
    // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    invalid_d = invalid_q;
    base      = {idx_q, 2'b00};
    digit_a   = a_q[base +: 4];
    digit_b   = b_q[base +: 4];
    last      = (idx_q == LAST_IDX);
    res       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SUB;
          a_d       = a;
          b_d       = b;
          borrow_d  = bin;
          idx_d     = '0;
          invalid_d = 1'b0;
          bout_d    = 1'b0;
        end
      end
      S_SUB: begin
        res              = digit_sub(digit_a, digit_b, borrow_q);
        diff_d[base +: 4] = res[3:0];
        borrow_d         = res[4];
        if (digit_a > 4'd9 || digit_b > 4'd9) invalid_d = 1'b1;
        if (last) begin
          bout_d = res[4];
          idx_d  = '0;
`ifdef BCD_SUB_SIGN_MAG_EN
          if (res[4]) begin
            state_d  = S_NEG;
            borrow_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      // Magnitude pass: 0 - diff with the same digit rule turns ten's complement into |result|.
      S_NEG: begin
        res              = digit_sub(4'd0, diff_q[base +: 4], borrow_q);
        diff_d[base +: 4] = res[3:0];
        borrow_d         = res[4];
        if (last) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, including the operand copies, is cleared so an abandoned operation leaves no trace.
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      bout_q    <= bout_d;
      invalid_q <= invalid_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_DONE);
  assign diff    = diff_q;
  assign bout    = bout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): table vectors, random model ops, corner sequences.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
`ifdef BCD_SUB_SIGN_MAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif
  localparam int LAT_POS = DIGITS + 1;
  localparam int LAT_NEG = SM ? 2 * DIGITS + 1 : DIGITS + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        inv;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        ready, done, bout, invalid;
  logic [15:0] diff;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t sb_q[$];
  vec_t vecs[8];

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .done(done), .diff(diff), .bout(bout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [15:0] va, logic [15:0] vb, logic vbin,
                              logic [15:0] vd, logic vbo, logic vinv, int vlat);
    vec_t v;
    v.a = va; v.b = vb; v.bin = vbin; v.diff = vd; v.bout = vbo; v.inv = vinv; v.lat = vlat;
    return v;
  endfunction

  function automatic int bcd2int(logic [15:0] x);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(x[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Independent decimal model for valid operands.
  function automatic vec_t model(logic [15:0] va, logic [15:0] vb, logic vbin);
    int r;
    r = bcd2int(va) - bcd2int(vb) - int'(vbin);
    if (r < 0) begin
      r = SM ? -r : r + 10000;
      return mk(va, vb, vbin, int2bcd(r % 10000), 1'b1, 1'b0, LAT_NEG);
    end
    return mk(va, vb, vbin, int2bcd(r), 1'b0, 1'b0, LAT_POS);
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  // Runs one operation; optionally pokes start again at cycle poke_cyc with other operands.
  task automatic do_op(input vec_t v, input string name, input int poke_cyc);
    int   cyc = 0;
    bit   got = 1'b0;
    vec_t e;
    wait_ready(name);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'h9876; b = 16'h0123; bin = ~v.bin;
    check({name, "_inv_clr_at_accept"}, invalid, 0);
    check({name, "_busy"}, ready, 0);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        start = 1'b1; a = 16'h0001; b = 16'h0002; bin = 1'b1;
      end
      if (poke_cyc != 0 && cyc == poke_cyc + 1) start = 1'b0;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!got) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_diff"}, diff, e.diff);
      check({name, "_bout"}, bout, e.bout);
      check({name, "_invalid"}, invalid, e.inv);
      check({name, "_latency"}, cyc, e.lat);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
      check({name, "_ready_back"}, ready, 1);
      check({name, "_diff_hold"}, diff, e.diff);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    vecs[0] = mk(16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0, LAT_POS);
    vecs[1] = mk(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, LAT_POS);
    vecs[2] = mk(16'h0000, 16'h0001, 1'b0, SM ? 16'h0001 : 16'h9999, 1'b1, 1'b0, LAT_NEG);
    vecs[3] = mk(16'h0123, 16'h0123, 1'b1, SM ? 16'h0001 : 16'h9999, 1'b1, 1'b0, LAT_NEG);
    vecs[4] = mk(16'h0123, 16'h0123, 1'b0, 16'h0000, 1'b0, 1'b0, LAT_POS);
    vecs[5] = mk(16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0, LAT_NEG);
    vecs[6] = mk(16'h00A0, 16'h0000, 1'b0, 16'h00A0, 1'b0, 1'b1, LAT_POS);
    vecs[7] = mk(16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, LAT_POS);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_invalid", invalid, 0);

    // Table vectors; entry 7 follows the invalid-digit entry and must clear invalid.
    for (int i = 0; i < 8; i++) do_op(vecs[i], $sformatf("vec%0d", i), 0);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      for (int d = 0; d < DIGITS; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      do_op(model(ra, rb, 1'($urandom_range(0, 1))), $sformatf("rnd%0d", i), 0);
    end

    // Start pulsed while busy is ignored.
    do_op(vecs[0], "ignore_start", 2);

    // Reset during SUB abandons the operation.
    wait_ready("rst_mid");
    a = 16'h5432; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", ready, 1);
    check("rst_mid_diff", diff, 0);
    check("rst_mid_bout", bout, 0);
    check("rst_mid_done", done, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_mid_no_done", seen, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
